// File: rtl/ppe_row_engine.sv
// ppe_row_engine
// Partial-sum processing element sitting downstream of the IFMAP memory.
// It holds one filter row of signed 8-bit taps. For every spike row it
// receives, it emits one sliding-window partial sum per column position, then
// asks IFMAP memory for the next row.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : inbound packet valid
//   in_ready     : inbound packet accepted (high in WLOAD, WAIT_ROW and DONE)
//   in_packet    : [32:29] dest (ignored), [28:25] opcode, [24:0] data
//   out_valid    : outbound packet valid (high in COMPUTE and SEND_REQ)
//   out_ready    : router accepts the outbound packet
//   out_packet   : [32:29] dest, [28:25] opcode, [24:0] data
//   busy         : high while in COMPUTE or SEND_REQ
module ppe_row_engine #(
    parameter int PE_ID       = 5,
    parameter int IMEM_ID     = 10,
    parameter int PSUM_DEST   = 11,
    parameter int NUM_ROWS    = 21,
    parameter int IFMAP_SIZE  = 25,
    parameter int FILTER_SIZE = 5,
    parameter int SUM_WIDTH   = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:0] in_packet,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] out_packet,
    output logic        busy
);

    localparam int NUM_COLS = IFMAP_SIZE - FILTER_SIZE + 1;

    typedef enum logic [2:0] {
        WLOAD,
        WAIT_ROW,
        COMPUTE,
        SEND_REQ,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [7:0]       weights [FILTER_SIZE];
    logic [FILTER_SIZE-1:0]  mask;
    logic [IFMAP_SIZE-1:0]   row;
    logic [4:0]              row_cnt;
    logic [4:0]              col;
    logic                    started;

    logic [3:0]              in_op;
    logic [2:0]              w_idx;
    logic signed [7:0]       w_val;
    logic                    in_fire;
    logic                    out_fire;
    logic                    is_row;
    logic                    is_weight;
    logic                    is_tsdone;
    logic                    w_ok;
    logic [FILTER_SIZE-1:0]  w_bit;
    logic                    last_col;
    logic                    more_rows;
    logic [IFMAP_SIZE-1:0]   window;
    logic signed [SUM_WIDTH-1:0] psum;

    assign in_op     = in_packet[28:25];
    assign w_idx     = in_packet[2:0];
    assign w_val     = in_packet[15:8];
    assign is_row    = (in_op == 4'd1);
    assign is_weight = (in_op == 4'd2);
    assign is_tsdone = (in_op == 4'd10);
    assign w_ok      = (w_idx < 3'(FILTER_SIZE));
    assign w_bit     = FILTER_SIZE'(1) << w_idx;
    assign last_col  = (col == 5'(NUM_COLS - 1));
    assign more_rows = ((row_cnt + 5'd1) < 5'(NUM_ROWS));

    // started holds in_ready low through reset and for the first cycle after it
    assign in_ready  = started && (state == WLOAD || state == WAIT_ROW || state == DONE);
    assign out_valid = (state == COMPUTE) || (state == SEND_REQ);
    assign busy      = out_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Window sum: tap k sees spike column col+k; each weight is sign-extended
    // to the sum width, so the result cannot overflow.
    always_comb begin
        window = row >> col;
        psum   = '0;
        for (int k = 0; k < FILTER_SIZE; k++) begin
            if (window[k]) begin
                psum = psum + SUM_WIDTH'(weights[k]);
            end
        end
    end

    // Outbound packet is purely a function of state and registers, so it stays
    // stable for as long as the router stalls.
    always_comb begin
        out_packet = '0;
        if (state == COMPUTE) begin
            out_packet = {4'(PSUM_DEST), 4'd3, row_cnt, col, 2'b00, 13'(psum)};
        end else if (state == SEND_REQ) begin
            out_packet = {4'(IMEM_ID), 4'(PE_ID), 25'd0};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WLOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            WLOAD: begin
                if (in_fire && is_weight && w_ok && (&(mask | w_bit))) begin
                    state_next = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (in_fire && is_row) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (out_fire && last_col) begin
                    state_next = more_rows ? SEND_REQ : DONE;
                end
            end
            SEND_REQ: begin
                if (out_fire) begin
                    state_next = WAIT_ROW;
                end
            end
            DONE: begin
                if (in_fire && is_tsdone) begin
                    state_next = WAIT_ROW;
                end
            end
            default: state_next = WLOAD;
        endcase
    end

    // Datapath registers: taps, load mask, latched row and the two counters.
    // Weight writes are accepted in every state that takes input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FILTER_SIZE; k++) begin
                weights[k] <= '0;
            end
            mask    <= '0;
            row     <= '0;
            row_cnt <= '0;
            col     <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (in_fire && is_weight && w_ok) begin
                weights[w_idx] <= w_val;
                mask[w_idx]    <= 1'b1;
            end
            if (in_fire && is_row && state == WAIT_ROW) begin
                row <= in_packet[IFMAP_SIZE-1:0];
                col <= '0;
            end
            if (in_fire && is_tsdone && (state == WAIT_ROW || state == DONE)) begin
                row_cnt <= '0;
            end
            if (out_fire && state == COMPUTE) begin
                if (last_col) begin
                    row_cnt <= row_cnt + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppe_row_engine.sv
// tb_ppe_row_engine
// Self-checking bench for ppe_row_engine. Expected outbound packets are
// pushed to a queue whenever a row is sent and are popped as the DUT emits
// them.
module tb_ppe_row_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] in_packet = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] out_packet;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    int tw[5];
    int rc;

    always #5 clk = ~clk;

    ppe_row_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_packet(in_packet),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_packet(out_packet),
        .busy(busy)
    );

    // Reference window sum from the bench's own copy of the taps
    function automatic logic [12:0] psum_of(input logic [24:0] r, input int c);
        int s = 0;
        for (int k = 0; k < 5; k++) begin
            if (r[c + k]) s += tw[k];
        end
        return 13'(s);
    endfunction

    // Queue the 21 psums of one row, plus the follow-up request if more rows remain
    task automatic push_row(input logic [24:0] r);
        for (int c = 0; c < 21; c++) begin
            exp_q.push_back({4'd11, 4'd3, 5'(rc), 5'(c), 2'b00, psum_of(r, c)});
        end
        rc++;
        if (rc < 21) exp_q.push_back({4'd10, 4'd5, 25'd0});
    endtask

    // Present one inbound packet and hold it until accepted (bounded)
    task automatic send_pkt(input logic [3:0] op, input logic [24:0] d);
        int cyc = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_packet = {4'hE, op, d};
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_timeout: in_ready=%b required 1 (op %0d)", in_ready, op);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_weight(input int idx, input int w);
        send_pkt(4'd2, {9'd0, 8'(w), 5'd0, 3'(idx)});
        if (idx < 5) tw[idx] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rc = 0;
        for (int k = 0; k < 5; k++) tw[k] = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (out_packet !== 33'd0) begin errors++; $display("[TB] FAIL reset_out_packet: got %h required 0", out_packet); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        do_reset();
    endtask

    task automatic test_all_ones();
        logic [32:0] exp;
        int cyc;
        for (int k = 0; k < 5; k++) send_weight(k, k + 1);
        send_pkt(4'd1, 25'h1FFFFFF);
        push_row(25'h1FFFFFF);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            cyc = 0;
            while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_packet !== exp) begin
                errors++;
                $display("[TB] FAIL all_ones_pkt: got %h (valid %b) required %h", out_packet, out_valid, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL all_ones_wait_row: busy=%b in_ready=%b required 0/1", busy, in_ready);
        end
    endtask

    task automatic test_signed();
        logic [32:0] exp;
        int cyc;
        send_weight(0, -128);
        send_weight(1, 127);
        send_weight(2, 0);
        send_weight(3, 0);
        send_weight(4, -128);
        send_pkt(4'd7, 25'h1234567);
        send_pkt(4'd1, 25'h0000013);
        push_row(25'h0000013);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            cyc = 0;
            while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_packet !== exp) begin
                errors++;
                $display("[TB] FAIL signed_pkt: got %h (valid %b) required %h", out_packet, out_valid, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_early_row();
        logic [32:0] exp;
        int cyc;
        do_reset();
        send_pkt(4'd1, 25'h1FFFFFF);
        send_weight(5, 99);
        for (int k = 0; k < 4; k++) send_weight(k, 3 * k - 4);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_row_partial: out_valid=%b required 0", out_valid); end
        end
        out_ready = 1'b0;
        send_weight(4, 7);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL early_row_dropped: out_valid=%b busy=%b required 0/0", out_valid, busy);
            end
        end
        send_pkt(4'd1, 25'h0A5A5A5);
        push_row(25'h0A5A5A5);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            cyc = 0;
            while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_packet !== exp) begin
                errors++;
                $display("[TB] FAIL early_row_pkt: got %h (valid %b) required %h", out_packet, out_valid, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    // Stall at column 7, then expect one packet per cycle with no gaps
    task automatic test_backpressure();
        logic [32:0] exp;
        int n = 0;
        send_pkt(4'd1, 25'h15F0C3A);
        push_row(25'h15F0C3A);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (n == 7) begin
                out_ready = 1'b0;
                repeat (4) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_packet !== exp) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got %h (valid %b) required %h", out_packet, out_valid, exp);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_packet !== exp) begin
                errors++;
                $display("[TB] FAIL stall_stream: item %0d got %h (valid %b) required %h", n, out_packet, out_valid, exp);
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_timestep();
        logic [32:0] exp;
        logic [24:0] r;
        int cyc;
        int reqs = 0;
        do_reset();
        for (int k = 0; k < 5; k++) send_weight(k, $urandom_range(0, 255) - 128);
        for (int i = 0; i < 22; i++) begin
            if (i == 21) begin
                send_pkt(4'd10, 25'd0);
                rc = 0;
            end
            r = 25'($urandom);
            send_pkt(4'd1, r);
            push_row(r);
            out_ready = 1'b1;
            while (exp_q.size() > 0) begin
                cyc = 0;
                while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
                exp = exp_q.pop_front();
                if (exp[28:25] == 4'd5) reqs++;
                checks++;
                if (out_valid !== 1'b1 || out_packet !== exp) begin
                    errors++;
                    $display("[TB] FAIL timestep_pkt: row %0d got %h (valid %b) required %h", i, out_packet, out_valid, exp);
                end
                @(negedge clk);
            end
            if (i == 20) begin
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL timestep_done: out_valid=%b busy=%b in_ready=%b required 0/0/1",
                                 out_valid, busy, in_ready);
                    end
                end
                checks++;
                if (reqs != 20) begin errors++; $display("[TB] FAIL timestep_requests: got %0d required 20", reqs); end
            end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [32:0] exp;
        int cyc;
        do_reset();
        for (int k = 0; k < 5; k++) send_weight(k, 10 * k + 1);
        send_pkt(4'd1, 25'h1FFFFFF);
        push_row(25'h1FFFFFF);
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc = 0;
            while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_packet !== exp) begin
                errors++;
                $display("[TB] FAIL pre_reset_pkt: got %h (valid %b) required %h", out_packet, out_valid, exp);
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_packet !== exp) begin
            errors++;
            $display("[TB] FAIL pre_reset_col10: got %h (valid %b) required %h", out_packet, out_valid, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_packet !== 33'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: out_valid=%b busy=%b pkt=%h in_ready=%b required 0/0/0/0",
                     out_valid, busy, out_packet, in_ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(4'd1, 25'h1FFFFFF);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_wload: out_valid=%b busy=%b required 0/0", out_valid, busy);
            end
        end
        out_ready = 1'b0;
    endtask

    // Test sequence
    initial begin
        rc = 0;
        for (int k = 0; k < 5; k++) tw[k] = 0;
        test_reset();
        test_all_ones();
        test_signed();
        test_early_row();
        test_backpressure();
        test_full_timestep();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
